dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-port responder for the core: word RAM plus an MMIO window with a cycle
// counter, a console TX FIFO and sticky error flags. Loads are answered combinationally.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_out,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] mem_data_in,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        err_flag
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam int unsigned PW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  FULL_CNT = 3'(FIFO_DEPTH);

    localparam logic [15:0] OFF_CYCLE  = 16'h0000;
    localparam logic [15:0] OFF_CON_TX = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_CLEAR  = 16'h000C;

    logic [31:0]   ram_r [DEPTH_WORDS];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [31:0]   cycle_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [2:0]    count_r;
    logic          ovf_r;
    logic          mis_r;
    logic          con_valid_r;
    logic [7:0]    con_data_r;
    logic          err_flag_r;

    logic          is_mmio_s;
    logic          aligned_s;
    logic [15:0]   offset_s;
    logic [AW-1:0] ram_idx_s;
    logic          ram_we_s;
    logic          push_s;
    logic          clr_wr_s;
    logic          pop_s;
    logic          do_push_s;
    logic          full_s;
    logic          empty_s;
    logic          ovf_nxt_s;
    logic          mis_nxt_s;
    logic [2:0]    count_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [7:0]    head_nxt_s;
    logic [31:0]   status_s;
    logic [31:0]   rdata_s;

    assign is_mmio_s = (mem_addr[31:16] == MMIO_HI);
    assign aligned_s = (mem_addr[1:0] == 2'b00);
    assign offset_s  = mem_addr[15:0];
    assign ram_idx_s = mem_addr[AW+1:2];
    assign full_s    = (count_r == FULL_CNT);
    assign empty_s   = (count_r == 3'd0);
    assign status_s  = {25'h0, count_r, mis_r, ovf_r, empty_s, full_s};

    // Load data mux: zero when idle or misaligned, otherwise MMIO register or RAM word
    always_comb begin
        rdata_s = 32'h0;
        if (!mem_read || !aligned_s) begin
            rdata_s = 32'h0;
        end else if (is_mmio_s) begin
            case (offset_s)
                OFF_CYCLE:  rdata_s = cycle_r;
                OFF_STATUS: rdata_s = status_s;
                default:    rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = ram_r[ram_idx_s];
        end
    end

    assign mem_data_in = rdata_s;

    // Store decode, FIFO next-state and sticky flag next-state
    always_comb begin
        ram_we_s  = mem_write && aligned_s && !is_mmio_s;
        push_s    = mem_write && aligned_s && is_mmio_s && (offset_s == OFF_CON_TX);
        clr_wr_s  = mem_write && aligned_s && is_mmio_s && (offset_s == OFF_CLEAR);
        pop_s     = con_valid_r && con_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        do_push_s = push_s && (!full_s || pop_s);

        if (push_s && full_s && !pop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_wr_s && mem_data_out[2]) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        if ((mem_read || mem_write) && !aligned_s) begin
            mis_nxt_s = 1'b1;
        end else if (clr_wr_s && mem_data_out[3]) begin
            mis_nxt_s = 1'b0;
        end else begin
            mis_nxt_s = mis_r;
        end

        count_nxt_s = count_r + {2'b00, do_push_s} - {2'b00, pop_s};

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (do_push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // Head after this edge: the incoming byte if it lands in the new head slot
        if (count_nxt_s == 3'd0) begin
            head_nxt_s = 8'h00;
        end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = mem_data_out[7:0];
        end else begin
            head_nxt_s = fifo_r[rd_ptr_nxt_s];
        end
    end

    // Word RAM: contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= mem_data_out;
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r <= 32'h0;
        end else begin
            cycle_r <= cycle_r + 32'h1;
        end
    end

    // Console FIFO storage, pointers and registered console outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_r[i] <= 8'h00;
            end
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= 3'd0;
            con_valid_r <= 1'b0;
            con_data_r  <= 8'h00;
        end else begin
            if (do_push_s) begin
                fifo_r[wr_ptr_r] <= mem_data_out[7:0];
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            con_valid_r <= (count_nxt_s != 3'd0);
            con_data_r  <= head_nxt_s;
        end
    end

    // Sticky error flags and their registered summary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r      <= 1'b0;
            mis_r      <= 1'b0;
            err_flag_r <= 1'b0;
        end else begin
            ovf_r      <= ovf_nxt_s;
            mis_r      <= mis_nxt_s;
            err_flag_r <= ovf_nxt_s | mis_nxt_s;
        end
    end

    assign con_valid = con_valid_r;
    assign con_data  = con_data_r;
    assign err_flag  = err_flag_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected load data and
// console bytes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_responder;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_CON_TX = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_CLEAR  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_data_out = 32'h0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] mem_data_in;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        err_flag;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  con_q[$];
    logic [31:0] cyc_m;
    logic [31:0] t0;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .FIFO_DEPTH (4),
        .MMIO_HI    (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_data_out(mem_data_out),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_data_in (mem_data_in),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready),
        .err_flag    (err_flag)
    );

    always #5 clk = ~clk;

    // Reference count of posedges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_m <= 32'h0;
        else        cyc_m <= cyc_m + 32'h1;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: compare load data and console bytes against the scoreboard
    always @(negedge clk) begin
        if (mem_read) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", mem_data_in, 32'hxxxx_xxxx);
            end else begin
                chk(name_q.pop_front(), mem_data_in, exp_q.pop_front());
            end
        end
        if (con_valid && con_ready) begin
            if (con_q.size() == 0) begin
                chk("con_unexpected", {24'h0, con_data}, 32'hxxxx_xxxx);
            end else begin
                chk("con_byte", {24'h0, con_data}, {24'h0, con_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        mem_addr = a; mem_read = 1'b1; mem_write = 1'b0;
        exp_q.push_back(e); name_q.push_back(n);
        cyc();
        mem_read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a; mem_data_out = d; mem_write = 1'b1; mem_read = 1'b0;
        cyc();
        mem_write = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
        mem_addr = a; mem_data_out = d; mem_write = 1'b1; mem_read = 1'b1;
        exp_q.push_back(e); name_q.push_back(n);
        cyc();
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        con_q.push_back(b);
        wr(A_CON_TX, {24'h0, b});
    endtask

    task automatic drain(input string n);
        con_ready = 1'b1;
        for (int i = 0; i < 16 && con_valid; i++) cyc();
        chk(n, {31'h0, con_valid}, 32'h0);
        con_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_con_valid", {31'h0, con_valid}, 32'h0);
        chk("rst_con_data", {24'h0, con_data}, 32'h0);
        chk("rst_err_flag", {31'h0, err_flag}, 32'h0);
        repeat (2) cyc();
        rst_n = 1'b1;
        rd(A_CYCLE, 32'h0, "cycle_at_release");
        rd(A_STATUS, 32'h02, "status_reset");
        mem_addr = 32'h100;
        #1 chk("rdata_idle", mem_data_in, 32'h0);

        // RAM, aliasing and read-during-write
        wr(32'h100, 32'hDEADBEEF);
        rd(32'h100, 32'hDEADBEEF, "ram_rd");
        rd(32'h100 + DEPTH_WORDS * 4, 32'hDEADBEEF, "ram_alias");
        wr(32'h104, 32'h1111_1111);
        rw(32'h104, 32'h2222_2222, 32'h1111_1111, "ram_rw_old");
        rd(32'h104, 32'h2222_2222, "ram_rw_new");

        // Misalignment
        wr(32'h102, 32'hCAFE_F00D);
        chk("err_after_misalign", {31'h0, err_flag}, 32'h1);
        rd(32'h100, 32'hDEADBEEF, "ram_unchanged");
        rd(A_STATUS, 32'h0A, "status_misalign");
        wr(A_CLEAR, 32'h8);
        chk("err_after_clear", {31'h0, err_flag}, 32'h0);
        rd(A_STATUS, 32'h02, "status_cleared");
        rd(32'h101, 32'h0, "misalign_rd_zero");
        rd(A_STATUS, 32'h0A, "status_misalign_rd");
        wr(A_CLEAR, 32'h8);
        rd(A_CON_TX, 32'h0, "con_tx_reads_zero");
        rd(32'hFFFF_0010, 32'h0, "mmio_unmapped");

        // Cycle counter distance
        t0 = cyc_m;
        rd(A_CYCLE, t0, "cycle_a");
        repeat (7) cyc();
        rd(A_CYCLE, t0 + 32'd8, "cycle_b");

        // Console fill, overflow, drain
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43); push_byte(8'h44);
        rd(A_STATUS, 32'h41, "status_full");
        wr(A_CON_TX, 32'h45);
        rd(A_STATUS, 32'h45, "status_overflow");
        chk("err_overflow", {31'h0, err_flag}, 32'h1);
        wr(A_CLEAR, 32'h4);
        chk("err_ovf_cleared", {31'h0, err_flag}, 32'h0);
        rd(A_STATUS, 32'h41, "status_full_clr");
        drain("drain1_done");
        rd(A_STATUS, 32'h02, "status_drained");

        // Push and pop together while full
        push_byte(8'h51); push_byte(8'h52); push_byte(8'h53); push_byte(8'h54);
        con_ready = 1'b1;
        push_byte(8'h55);
        con_ready = 1'b0;
        rd(A_STATUS, 32'h41, "status_push_pop_full");
        drain("drain2_done");
        rd(A_STATUS, 32'h02, "status_drained2");

        // Reset with bytes queued
        wr(A_CON_TX, 32'h61);
        wr(A_CON_TX, 32'h62);
        cyc();
        chk("queued_valid", {31'h0, con_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_con_valid", {31'h0, con_valid}, 32'h0);
        chk("midrst_con_data", {24'h0, con_data}, 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        rd(A_CYCLE, 32'h0, "cycle_after_rst2");
        rd(A_STATUS, 32'h02, "status_after_rst2");
        con_ready = 1'b1;
        repeat (3) cyc();
        chk("lost_bytes", {31'h0, con_valid}, 32'h0);
        con_ready = 1'b0;

        chk("sb_empty", exp_q.size() + con_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
